// File: rtl/tx_msg_pkg.sv
// Shared definitions for the UART status-message formatter.
// Contents:
//   - mode codes carried on i_mode
//   - ASCII constants and the fixed text fragments of the line
//   - state_name_char(): one character of the state name selected by a mode code.
//     It returns 8'h00 past the end of the name so that the caller can apply its own
//     pad character.
//   - FSM state type of the formatter
package tx_msg_pkg;

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_RATE = 2'd1;
  localparam logic [1:0] MODE_INIT = 2'd2;
  localparam logic [1:0] MODE_NORM = 2'd3;

  localparam logic [7:0] SPACE   = 8'h20;
  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] DIGIT_0 = 8'h30;

  localparam int unsigned PREFIX_LEN = 14;
  localparam logic [8*PREFIX_LEN-1:0] PREFIX_STR = "current state:";

  localparam int unsigned LABEL_LEN = 7;
  localparam logic [8*LABEL_LEN-1:0] LABEL_STR = {SPACE, SPACE, "rate", COLON};

  localparam int unsigned NAME_MAX = 12;
  localparam logic [8*NAME_MAX-1:0] NAME_RATE = "rate control";
  localparam logic [8*NAME_MAX-1:0] NAME_INIT = {40'h0, "initial"};
  localparam logic [8*NAME_MAX-1:0] NAME_NORM = {48'h0, "normal"};

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StEmit
  } fmt_state_e;

  // Character 'pos' (0 = leftmost) of the name for 'mode'; 8'h00 beyond its end.
  function automatic logic [7:0] state_name_char(input logic [1:0] mode, input int unsigned pos);
    logic [8*NAME_MAX-1:0] name;
    int unsigned           len;
    logic [7:0]            c;
    name = '0;
    len  = 0;
    c    = 8'h00;
    case (mode)
      MODE_RATE: begin name = NAME_RATE; len = 12; end
      MODE_INIT: begin name = NAME_INIT; len = 7;  end
      MODE_NORM: begin name = NAME_NORM; len = 6;  end
      default:   begin name = '0;        len = 0;  end
    endcase
    // Names are right-aligned in 'name', so char pos sits at byte len-1-pos.
    if (pos < len) c = name[8*(len-1-pos) +: 8];
    return c;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load 'bin' and begin; a start while running restarts the conversion
//   bin        : binary input, sampled on the start cycle
//   done       : one-cycle pulse, RATE_W cycles after the start edge
//   bcd        : packed BCD result, most significant digit in the top nibble; held until
//                the next start
module bin2bcd_seq #(
  parameter int unsigned RATE_W      = 8,
  parameter int unsigned RATE_DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [RATE_W-1:0]        bin,
  output logic                     done,
  output logic [4*RATE_DIGITS-1:0] bcd
);

  localparam int unsigned CntW = $clog2(RATE_W + 1);

  logic [RATE_W-1:0]        bin_q, bin_d;
  logic [4*RATE_DIGITS-1:0] bcd_q, bcd_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [4*RATE_DIGITS-1:0] adj;

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    adj    = bcd_q;
    if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = CntW'(RATE_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Add 3 to any digit >= 5 so that the following shift carries correctly.
      for (int unsigned d = 0; d < RATE_DIGITS; d++) begin
        if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/tx_msg_formatter.sv
// UART status-message generator.
// On an accepted request emits "current state:<FIELD>  rate:<DDD><LINE_TERM>" one byte at a
// time over a valid/ready handshake.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_send      : request one line (only honoured in IDLE with a non-zero mode)
//   i_mode      : state-name selector (0 none, 1 rate control, 2 initial, 3 normal)
//   i_rate      : binary rate value, printed as right-aligned decimal
//   o_tx_data   : registered ASCII byte (8'hFF when no byte is offered)
//   o_tx_valid  : o_tx_data is offered
//   i_tx_ready  : UART takes the byte this cycle
//   o_busy      : a line is in progress
//   o_done      : one-cycle pulse after the line terminator is taken
module tx_msg_formatter
  import tx_msg_pkg::*;
#(
  parameter int unsigned RATE_W      = 8,
  parameter int unsigned RATE_DIGITS = 3,
  parameter int unsigned FIELD_W     = 12,
  parameter logic [7:0]  LINE_TERM   = 8'h0A,
  parameter logic [7:0]  PAD_CHAR    = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_send,
  input  logic [1:0]        i_mode,
  input  logic [RATE_W-1:0] i_rate,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned FieldOff = PREFIX_LEN;
  localparam int unsigned LabelOff = FieldOff + FIELD_W;
  localparam int unsigned DigOff   = LabelOff + LABEL_LEN;
  localparam int unsigned TermIdx  = DigOff + RATE_DIGITS;
  localparam int unsigned Len      = TermIdx + 1;
  localparam int unsigned IdxW     = $clog2(Len);

  if ((10 ** RATE_DIGITS) <= (2 ** RATE_W) - 1) begin : g_bad_digits
    $error("RATE_DIGITS too small to hold the largest RATE_W-bit value");
  end

  fmt_state_e               state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [1:0]               mode_q, mode_d;
  logic [7:0]               data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     conv_start;
  logic                     conv_done;
  logic [4*RATE_DIGITS-1:0] conv_bcd;

  // Byte 'i' of the line for the latched mode and converted rate.
  function automatic logic [7:0] line_byte(input int unsigned              i,
                                           input logic [1:0]               mode,
                                           input logic [4*RATE_DIGITS-1:0] bcd);
    logic [7:0] c;
    logic [3:0] dig;
    logic       lead;
    c    = LINE_TERM;
    lead = 1'b1;
    dig  = 4'd0;
    if (i < FieldOff) begin
      c = PREFIX_STR[8*(PREFIX_LEN-1-i) +: 8];
    end else if (i < LabelOff) begin
      c = state_name_char(mode, i - FieldOff);
      if (c == 8'h00) c = PAD_CHAR;
    end else if (i < DigOff) begin
      c = LABEL_STR[8*(LABEL_LEN-1-(i-LabelOff)) +: 8];
    end else if (i < TermIdx) begin
      c = PAD_CHAR;
      // 'lead' stays set while every digit so far is zero; the last digit always prints.
      for (int unsigned d = 0; d < RATE_DIGITS; d++) begin
        dig = bcd[4*(RATE_DIGITS-1-d) +: 4];
        if (dig != 4'd0 || d == RATE_DIGITS - 1) lead = 1'b0;
        if (d == i - DigOff) c = lead ? PAD_CHAR : DIGIT_0 + {4'h0, dig};
      end
    end
    return c;
  endfunction

  assign conv_start = (state_q == StIdle) && i_send && (i_mode != MODE_NONE);

  bin2bcd_seq #(
    .RATE_W     (RATE_W),
    .RATE_DIGITS(RATE_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .reset(reset),
    .start(conv_start),
    .bin  (i_rate),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (conv_start) begin
          state_d = StConv;
          mode_d  = i_mode;
          busy_d  = 1'b1;
        end
      end
      StConv: begin
        if (conv_done) begin
          state_d = StEmit;
          idx_d   = '0;
          valid_d = 1'b1;
          data_d  = line_byte(0, mode_q, conv_bcd);
        end
      end
      StEmit: begin
        if (valid_q && i_tx_ready) begin
          if (32'(idx_q) == Len - 1) begin
            state_d = StIdle;
            idx_d   = '0;
            valid_d = 1'b0;
            data_d  = 8'hFF;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + IdxW'(1);
            data_d = line_byte(32'(idx_q) + 1, mode_q, conv_bcd);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      mode_q  <= MODE_NONE;
      data_q  <= 8'hFF;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_tx_data  = data_q;
  assign o_tx_valid = valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_tx_msg_formatter.sv
module tb_tx_msg_formatter;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_send;
  logic [1:0] i_mode;
  logic [7:0] i_rate;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic       o_busy;
  logic       o_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  bit         expect_done = 1'b0;
  bit         ready_mode = 1'b0;

  tx_msg_formatter dut (
    .clk       (clk),
    .reset     (reset),
    .i_send    (i_send),
    .i_mode    (i_mode),
    .i_rate    (i_rate),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic send(input logic [1:0] m, input logic [7:0] r);
    @(posedge clk); #1;
    i_send = 1'b1; i_mode = m; i_rate = r;
    @(posedge clk); #1;
    i_send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 400);
    check(name, 32'(o_done), 32'd1);
  endtask

  task automatic wait_xfer(input int target);
    int n = 0;
    while (xfer_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("xfer_reached", 32'(xfer_cnt >= target), 32'd1);
  endtask

  // Ready generator: always 1, or 1 on one cycle out of three.
  initial begin
    int ph = 0;
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode) begin
        ph = (ph + 1) % 3;
        i_tx_ready = (ph == 0);
      end else begin
        i_tx_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks handshake behaviour.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      stall_prev  = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (o_done) done_cnt++;
      if (expect_done) begin
        check("done_pulse", {30'h0, o_done, o_tx_valid}, 32'h2);
        check("idle_data", 32'(o_tx_data), 32'hFF);
        expect_done = 1'b0;
      end else if (o_done) begin
        check("spurious_done", 32'(o_done), 32'd0);
      end
      if (stall_prev) begin
        check("stall_hold", {23'h0, o_tx_valid, o_tx_data}, {23'h0, 1'b1, stall_data});
      end
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(o_tx_data), 32'h100);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'(o_tx_data), 32'(e));
          if (e == 8'h0A) expect_done = 1'b1;
        end
        xfer_cnt++;
        stall_prev = 1'b0;
      end else if (o_tx_valid) begin
        stall_prev = 1'b1;
        stall_data = o_tx_data;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    bit saw_valid, saw_busy;
    reset = 1'b1; i_send = 1'b0; i_mode = 2'd0; i_rate = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", 32'(o_tx_data), 32'hFF);
    check("rst_valid", 32'(o_tx_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: normal, 100, ready tied high; first valid 9 cycles after accept.
    push_line("current state:normal        rate:100\n");
    send(2'd3, 8'd100);
    cycles = 0;
    @(negedge clk);
    check("busy_after_send", 32'(o_busy), 32'd1);
    while (!o_tx_valid && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    check("first_valid_latency", 32'(cycles), 32'd9);
    wait_done("t1_done");
    check("busy_clear", 32'(o_busy), 32'd0);

    // 2: rate control, 5 / 0 / 255, the latter two sent back to back.
    push_line("current state:rate control  rate:  5\n");
    send(2'd1, 8'd5);
    wait_done("t2a_done");
    push_line("current state:rate control  rate:  0\n");
    i_send = 1'b1; i_mode = 2'd1; i_rate = 8'd0;
    @(posedge clk); #1;
    i_send = 1'b0;
    wait_done("t2b_done");
    push_line("current state:rate control  rate:255\n");
    i_send = 1'b1; i_mode = 2'd1; i_rate = 8'd255;
    @(posedge clk); #1;
    i_send = 1'b0;
    wait_done("t2c_done");

    // 3: initial, 42, ready one cycle in three.
    ready_mode = 1'b1;
    push_line("current state:initial       rate: 42\n");
    send(2'd2, 8'd42);
    wait_done("t3_done");
    ready_mode = 1'b0;

    // 4a: send with mode 0 is ignored.
    send(2'd0, 8'd9);
    saw_valid = 1'b0; saw_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_valid |= o_tx_valid;
      saw_busy  |= o_busy;
    end
    check("mode0_no_valid", 32'(saw_valid), 32'd0);
    check("mode0_no_busy", 32'(saw_busy), 32'd0);

    // 4b: send during EMIT is ignored.
    push_line("current state:normal        rate:100\n");
    send(2'd3, 8'd100);
    wait_xfer(xfer_cnt + 12);
    send(2'd2, 8'd1);
    wait_done("t4b_done");
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw_valid |= o_tx_valid;
    end
    check("no_second_line", 32'(saw_valid), 32'd0);

    // 5: inputs change mid-line; latched values print.
    push_line("current state:normal        rate:  7\n");
    send(2'd3, 8'd7);
    wait_xfer(xfer_cnt + 15);
    i_mode = 2'd1; i_rate = 8'd200;
    wait_done("t5_done");

    // 6: reset mid-line, then a full line.
    push_line("current state:rate control  rate:123\n");
    send(2'd1, 8'd123);
    wait_xfer(xfer_cnt + 14);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(o_tx_valid), 32'd0);
    check("midrst_data", 32'(o_tx_data), 32'hFF);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    push_line("current state:initial       rate: 99\n");
    send(2'd2, 8'd99);
    wait_done("t6_done");
    repeat (5) @(negedge clk);

    check("done_count", 32'(done_cnt), 32'd8);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
